// File: rtl/clk_div_prog.sv
// Programmable clock divider with 50% duty for odd and even ratios.
// The ratio is reconfigured through a valid/ready port and applied only at a period boundary.
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DIV_DEFAULT = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [WIDTH-1:0] div_act,
   output logic             period_start,
   output logic             clk_div
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] div_act_reg, div_act_next;
   logic [WIDTH-1:0] pend_div_reg, pend_div_next;
   logic             pend_valid_reg, pend_valid_next;
   logic             running_reg, running_next;
   logic             pos_q_reg, pos_q_next;
   logic             neg_q_reg;
   logic             cfg_ready_reg, cfg_ready_next;
   logic             cfg_err_reg, cfg_err_next;
   logic             period_start_reg, period_start_next;

   logic             accept, bad_ratio, good_ratio;
   logic             boundary, load, start;
   logic [WIDTH-1:0] cnt_inc;

   assign accept     = cfg_valid && cfg_ready_reg;
   assign bad_ratio  = accept && (cfg_div < WIDTH'(2));
   assign good_ratio = accept && !bad_ratio;
   // While stopped every posedge counts as a boundary, so pending ratios and restarts take effect at once.
   assign boundary   = !running_reg || (cnt_reg == div_act_reg - WIDTH'(1));
   assign load       = boundary && pend_valid_reg;
   assign start      = boundary && en;
   assign cnt_inc    = cnt_reg + WIDTH'(1);

   always_comb begin
      cnt_next          = cnt_reg;
      div_act_next      = div_act_reg;
      pend_div_next     = pend_div_reg;
      pend_valid_next   = pend_valid_reg;
      running_next      = running_reg;
      pos_q_next        = pos_q_reg;
      cfg_ready_next    = cfg_ready_reg;
      cfg_err_next      = bad_ratio;
      period_start_next = start;

      if (boundary) begin
         cnt_next     = '0;
         running_next = en;
         // A new period always opens with the high phase, whatever ratio it uses.
         pos_q_next   = start;
      end else begin
         cnt_next   = cnt_inc;
         pos_q_next = (cnt_inc < (div_act_reg >> 1));
      end

      if (load) begin
         div_act_next    = pend_div_reg;
         pend_valid_next = 1'b0;
      end

      // pend_valid implies cfg_ready is low, so an accept can never coincide with a load.
      if (good_ratio) begin
         pend_div_next   = cfg_div;
         pend_valid_next = 1'b1;
         cfg_ready_next  = 1'b0;
      end else if (!cfg_ready_reg && !pend_valid_reg) begin
         cfg_ready_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg          <= '0;
         div_act_reg      <= DIV_RST;
         pend_div_reg     <= '0;
         pend_valid_reg   <= 1'b0;
         running_reg      <= 1'b0;
         pos_q_reg        <= 1'b0;
         cfg_ready_reg    <= 1'b1;
         cfg_err_reg      <= 1'b0;
         period_start_reg <= 1'b0;
      end else begin
         cnt_reg          <= cnt_next;
         div_act_reg      <= div_act_next;
         pend_div_reg     <= pend_div_next;
         pend_valid_reg   <= pend_valid_next;
         running_reg      <= running_next;
         pos_q_reg        <= pos_q_next;
         cfg_ready_reg    <= cfg_ready_next;
         cfg_err_reg      <= cfg_err_next;
         period_start_reg <= period_start_next;
      end
   end

   // Half-cycle delayed copy of pos_q stretches the high phase by half a clock for odd ratios.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q_reg <= 1'b0;
      end else begin
         neg_q_reg <= pos_q_reg;
      end
   end

   assign clk_div      = div_act_reg[0] ? (pos_q_reg | neg_q_reg) : pos_q_reg;
   assign cfg_ready    = cfg_ready_reg;
   assign cfg_err      = cfg_err_reg;
   assign div_act      = div_act_reg;
   assign period_start = period_start_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues the expected periods,
// a half-cycle monitor measures every divided period and checks it against the queue.
module tb_clk_div_prog;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_div = '0;
   logic       cfg_ready, cfg_err, period_start, clk_div;
   logic [7:0] div_act;

   clk_div_prog #(.WIDTH(8), .DIV_DEFAULT(9)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .cfg_valid    (cfg_valid),
      .cfg_div      (cfg_div),
      .cfg_ready    (cfg_ready),
      .cfg_err      (cfg_err),
      .div_act      (div_act),
      .period_start (period_start),
      .clk_div      (clk_div)
   );

   always #5 clk = ~clk;

   typedef struct {
      int div;
      int high_halves;
      bit gap;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void push(int d, int h, bit g);
      exp_t e;
      e.div = d;
      e.high_halves = h;
      e.gap = g;
      q.push_back(e);
   endfunction

   // Monitor: samples 1ns after every clock edge, i.e. once per half cycle.
   initial begin
      exp_t cur;
      bit   in_period = 0;
      bit   expect_next = 0;
      int   halves = 0;
      int   highs = 0;
      cur.div = 0; cur.high_halves = 0; cur.gap = 0;
      forever begin
         @(clk);
         #1;
         if (!rst_n) begin
            in_period = 0;
            expect_next = 0;
            chk("rst_clk_div", clk_div, 0);
         end else if (clk && period_start) begin
            chk("start_not_early", in_period, 0);
            chk("start_has_entry", int'(q.size() > 0), 1);
            expect_next = 0;
            in_period = 0;
            if (q.size() > 0) begin
               cur = q.pop_front();
               chk("start_div_act", div_act, cur.div);
               chk("start_clk_high", clk_div, 1);
               in_period = 1;
               halves = 1;
               highs = int'(clk_div);
            end
         end else if (in_period) begin
            halves++;
            highs += int'(clk_div);
            if (halves == 2 * cur.div) begin
               chk("high_halves", highs, cur.high_halves);
               $display("period N=%0d halves=%0d high_halves=%0d", cur.div, halves, highs);
               in_period = 0;
               expect_next = (q.size() > 0) && !q[0].gap;
            end
         end else begin
            if (clk && expect_next) begin
               chk("late_start", period_start, 1);
               expect_next = 0;
            end
            chk("idle_low", clk_div, 0);
         end
      end
   end

   task automatic wait_start(string tag);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (period_start) seen = 1;
      end
      chk(tag, seen, 1);
   endtask

   task automatic cfg_write(logic [7:0] v);
      bit rdy = 0;
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div = v;
      @(negedge clk);
      cfg_valid = 1'b0;
      for (int i = 0; i < 10 && !rdy; i++) begin
         @(posedge clk);
         #1;
         if (cfg_ready) rdy = 1;
      end
      chk("cfg_write_ready", rdy, 1);
      chk("cfg_write_div", div_act, v);
   endtask

   initial begin
      logic [7:0] bad_vals [2];
      bad_vals[0] = 8'd1;
      bad_vals[1] = 8'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_div_act", div_act, 9);
      chk("rst_period_start", period_start, 0);
      chk("rst_cfg_err", cfg_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_ready", cfg_ready, 1);

      // Default ratio 9, stop requested at cnt=2 of the third period
      push(9, 9, 1); push(9, 9, 0); push(9, 9, 0);
      @(negedge clk);
      en = 1'b1;
      wait_start("s1_start0");
      wait_start("s1_start1");
      wait_start("s1_start2");
      repeat (2) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      chk("s1_stopped_low", clk_div, 0);
      chk("s1_queue_drained", q.size(), 0);

      // Illegal ratios are flagged and ignored
      foreach (bad_vals[i]) begin
         @(negedge clk);
         cfg_valid = 1'b1;
         cfg_div = bad_vals[i];
         @(posedge clk);
         #1;
         chk("err_pulse", cfg_err, 1);
         chk("err_ready", cfg_ready, 1);
         chk("err_div_act", div_act, 9);
         @(negedge clk);
         cfg_valid = 1'b0;
         @(posedge clk);
         #1;
         chk("err_one_cycle", cfg_err, 0);
         chk("err_div_kept", div_act, 9);
      end

      // Ratio 4 accepted while stopped
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div = 8'd4;
      @(posedge clk);
      #1;
      chk("s3_ready_drop", cfg_ready, 0);
      chk("s3_div_pending", div_act, 9);
      @(negedge clk);
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("s3_div_loaded", div_act, 4);
      chk("s3_ready_still_low", cfg_ready, 0);
      @(posedge clk);
      #1;
      chk("s3_ready_back", cfg_ready, 1);
      push(4, 4, 1); push(4, 4, 0); push(4, 4, 0);
      @(negedge clk);
      en = 1'b1;
      wait_start("s3_start0");
      wait_start("s3_start1");
      wait_start("s3_start2");
      @(negedge clk);
      en = 1'b0;
      repeat (10) @(posedge clk);

      // Back to 9, then change to 6 at cnt=3 of a running period
      cfg_write(8'd9);
      push(9, 9, 1); push(6, 6, 0); push(6, 6, 0);
      @(negedge clk);
      en = 1'b1;
      wait_start("s4_start0");
      repeat (3) @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_div = 8'd6;
      @(posedge clk);
      #1;
      chk("s4_ready_drop", cfg_ready, 0);
      @(negedge clk);
      cfg_valid = 1'b0;
      begin
         bit seen = 0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (period_start) seen = 1;
            else chk("s4_ready_low_mid", cfg_ready, 0);
         end
         chk("s4_boundary_seen", seen, 1);
      end
      chk("s4_ready_at_boundary", cfg_ready, 0);
      chk("s4_div_at_boundary", div_act, 6);
      @(posedge clk);
      #1;
      chk("s4_ready_after", cfg_ready, 1);
      wait_start("s4_start2");
      @(negedge clk);
      en = 1'b0;
      repeat (15) @(posedge clk);

      // Reset while the divided clock is high
      push(6, 6, 1);
      @(negedge clk);
      en = 1'b1;
      wait_start("s5_start0");
      #3;
      chk("s5_high_before_rst", clk_div, 1);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_clk_div", clk_div, 0);
      chk("s5_rst_div_act", div_act, 9);
      chk("s5_rst_ready", cfg_ready, 1);
      chk("s5_rst_period_start", period_start, 0);
      repeat (2) @(posedge clk);
      push(9, 9, 1); push(9, 9, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_start("s5_start_after_rst");
      wait_start("s5_start_second");
      @(negedge clk);
      en = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      chk("final_queue_drained", q.size(), 0);
      chk("final_div_act", div_act, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the divide-ratio fields.
REQ-002 SHALL have parameter DIV_DEFAULT, default 9, divide ratio active out of reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1, single clock; both edges of clk are used internally.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, run enable for the divided clock.
REQ-006 SHALL have port cfg_valid, input, 1, a new ratio is offered on cfg_div.
REQ-007 SHALL have port cfg_div, input, WIDTH, requested divide ratio N.
REQ-008 SHALL have port cfg_ready, output, 1, a new ratio can be accepted.
REQ-009 SHALL have port cfg_err, output, 1, one-cycle pulse marking a rejected ratio.
REQ-010 SHALL have port div_act, output, WIDTH, ratio currently applied.
REQ-011 SHALL have port period_start, output, 1, one-cycle pulse on each posedge where a divided period begins.
REQ-012 SHALL have port clk_div, output, 1, divided clock at 50% duty for both odd and even N.

Function
REQ-013 SHALL keep a posedge counter cnt, 0..div_act-1, wrapping to 0 after div_act-1.
REQ-014 SHALL, on each running posedge, register pos_q <= (cnt < floor(div_act/2)).
REQ-015 SHALL register neg_q <= pos_q on each negedge of clk.
REQ-016 SHALL drive clk_div = pos_q for even div_act and pos_q OR neg_q for odd div_act.
REQ-017 SHALL therefore give period div_act clk cycles and high time div_act/2 cycles: N=9 gives 4.5 high and 4.5 low; N=4 gives 2 high and 2 low.
REQ-018 SHALL raise clk_div on the first posedge at which en=1 and rst_n has been sampled high, and assert period_start on that same edge.
REQ-019 SHALL define a period boundary as the posedge where cnt==div_act-1 while running, or any posedge while stopped.
REQ-020 SHALL accept cfg_div on the posedge where cfg_valid and cfg_ready are both 1.
REQ-021 SHALL, after an accept, drop cfg_ready and hold the value pending until the next period boundary.
REQ-022 SHALL, at that boundary, load div_act from the pending value so the next period uses it, then raise cfg_ready on the following cycle.
REQ-023 SHALL not truncate or stretch any high or low phase of the current period when the ratio changes; output stays glitch-free.
REQ-024 SHALL, for an accepted cfg_div < 2, pulse cfg_err for one cycle on the accept edge, leave div_act unchanged and keep cfg_ready at 1.
REQ-025 SHALL, when en falls, finish the current period, then hold cnt=0, pos_q=0, neg_q=0 and keep clk_div low.
REQ-026 SHALL, while stopped, apply a pending ratio on the next posedge.
REQ-027 SHALL, when en rises while stopped, start a period on the next posedge per REQ-018.
REQ-028 SHALL, on simultaneous en fall and a boundary, stop at that boundary with no new period_start.

Reset
REQ-029 SHALL, with rst_n=0, immediately and asynchronously force cnt=0, pos_q=0, neg_q=0, clk_div=0, period_start=0, cfg_err=0, cfg_ready=1, div_act=DIV_DEFAULT, and clear any pending ratio.
REQ-030 SHALL, on reset asserted mid-period, drop clk_div low at once; after release, operation restarts per REQ-018 using DIV_DEFAULT.

Verification
REQ-031 SHALL cover: reset released, en=1, DIV_DEFAULT=9 -> clk_div period 9 cycles, high exactly 4.5 cycles, period_start every 9 posedges.
REQ-032 SHALL cover: cfg_div=4 accepted while stopped, then en=1 -> period 4, high 2 cycles, div_act=4.
REQ-033 SHALL cover: running at 9, cfg_div=6 accepted at cnt=3 -> current period completes at 9, next periods are 6 with 3 high; cfg_ready low until boundary+1.
REQ-034 SHALL cover: cfg_div=1 offered -> cfg_err one-cycle pulse, div_act stays 9, cfg_ready stays 1.
REQ-035 SHALL cover: en dropped at cnt=2 of N=9 -> full period completes, clk_div then stays low, no further period_start.
REQ-036 SHALL cover: rst_n asserted while clk_div high -> clk_div=0 immediately, div_act=9 after release.
